// File: rtl/bldc_commutation_ctrl.sv
// Six-step trapezoidal BLDC commutation sequencer: align/run/brake FSM, velocity step timer,
// 8-bit PWM with slew-limited duty and dead-time insertion at every phase change.
module bldc_commutation_ctrl #(
    parameter int unsigned PRESC_SHIFT  = 4,
    parameter int unsigned DEAD_CYCLES  = 2,
    parameter int unsigned ALIGN_CYCLES = 1024,
    parameter logic [7:0]  ALIGN_DUTY   = 8'd32,
    parameter logic [7:0]  RAMP_STEP    = 8'd1,
    parameter int unsigned BRAKE_CYCLES = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] vel,
    input  logic [7:0] duty,
    output logic [2:0] phase_state,
    output logic [2:0] pwm_hi,
    output logic [2:0] pwm_lo,
    output logic       running
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_BRAKE = 2'd3;

    localparam int unsigned PW       = 9 + PRESC_SHIFT;
    localparam int unsigned HOLD_MAX = (ALIGN_CYCLES > BRAKE_CYCLES) ? ALIGN_CYCLES : BRAKE_CYCLES;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);
    localparam int unsigned DW       = $clog2(DEAD_CYCLES + 2);
    localparam logic [HW-1:0] ALIGN_LAST = HW'(ALIGN_CYCLES - 1);
    localparam logic [HW-1:0] BRAKE_LAST = HW'(BRAKE_CYCLES - 1);
    localparam logic [PW-1:0] PER_MIN    = PW'(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_INIT  = DW'(DEAD_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [PW-1:0] step_cnt_q, step_cnt_d;
    logic [PW-1:0] step_per_q, step_per_d;
    logic          stall_q, stall_d;
    logic [2:0]    phase_q, phase_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    duty_eff_q, duty_eff_d;
    logic [2:0]    pwm_hi_q, pwm_hi_d;
    logic [2:0]    pwm_lo_q, pwm_lo_d;
    logic          running_q, running_d;

    logic [PW-1:0] per_raw, per_lat;
    logic [7:0]    diff;
    logic [2:0]    hi_sel, lo_sel;
    logic          active_q, active_d, drive;

    always_comb begin
        per_raw = PW'(9'd256 - {1'b0, vel}) << PRESC_SHIFT;
        per_lat = (per_raw < PER_MIN) ? PER_MIN : per_raw;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_ALIGN;
            ST_ALIGN: if (!en) state_d = ST_BRAKE;
                      else if (hold_cnt_q == ALIGN_LAST) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_BRAKE;
            default:  if (hold_cnt_q == BRAKE_LAST) state_d = ST_IDLE;
        endcase
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RUN)
            hold_cnt_d = '0;
        else
            hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // Step timer: period latched at every step start; vel==0 freezes it and forces a relatch.
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_per_d = step_per_q;
        stall_d    = stall_q;
        phase_d    = phase_q;
        case (state_d)
            ST_ALIGN: begin
                phase_d    = 3'd1;
                step_cnt_d = '0;
                step_per_d = '0;
                stall_d    = 1'b0;
            end
            ST_RUN: begin
                if (state_q != ST_RUN) begin
                    phase_d    = 3'd1;
                    step_cnt_d = '0;
                    step_per_d = per_lat;
                    stall_d    = (vel == 8'd0);
                end else if (vel == 8'd0) begin
                    stall_d = 1'b1;
                end else if (stall_q) begin
                    step_cnt_d = '0;
                    step_per_d = per_lat;
                    stall_d    = 1'b0;
                end else if (step_cnt_q == step_per_q - 1'b1) begin
                    step_cnt_d = '0;
                    step_per_d = per_lat;
                    phase_d    = (phase_q == 3'd6) ? 3'd1 : phase_q + 3'd1;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: begin
                phase_d    = 3'd0;
                step_cnt_d = '0;
                step_per_d = '0;
                stall_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        active_q = (state_q == ST_ALIGN) || (state_q == ST_RUN);
        active_d = (state_d == ST_ALIGN) || (state_d == ST_RUN);
        pwm_cnt_d = '0;
        if (active_d && active_q)
            pwm_cnt_d = (pwm_cnt_q == 8'd254) ? '0 : pwm_cnt_q + 8'd1;

        diff = (duty > duty_eff_q) ? duty - duty_eff_q : duty_eff_q - duty;
        duty_eff_d = '0;
        if (state_d == ST_ALIGN || (state_d == ST_RUN && state_q != ST_RUN)) begin
            duty_eff_d = ALIGN_DUTY;
        end else if (state_d == ST_RUN) begin
            duty_eff_d = duty_eff_q;
            if (pwm_cnt_q == 8'd254) begin
                if (diff <= RAMP_STEP)
                    duty_eff_d = duty;
                else if (duty > duty_eff_q)
                    duty_eff_d = duty_eff_q + RAMP_STEP;
                else
                    duty_eff_d = duty_eff_q - RAMP_STEP;
            end
        end

        if (phase_d != phase_q || (state_d == ST_BRAKE && state_q != ST_BRAKE))
            dead_d = DEAD_INIT;
        else if (dead_q != '0)
            dead_d = dead_q - 1'b1;
        else
            dead_d = dead_q;
    end

    always_comb begin
        case (phase_d)
            3'd1:    begin hi_sel = 3'b001; lo_sel = 3'b010; end
            3'd2:    begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'd3:    begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'd4:    begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'd5:    begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'd6:    begin hi_sel = 3'b100; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
        drive     = active_d && (dead_d == '0);
        pwm_hi_d  = (drive && (pwm_cnt_d < duty_eff_d)) ? hi_sel : '0;
        if (drive)
            pwm_lo_d = lo_sel;
        else if (state_d == ST_BRAKE && dead_d == '0)
            pwm_lo_d = 3'b111;
        else
            pwm_lo_d = '0;
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            step_cnt_q <= '0;
            step_per_q <= '0;
            stall_q    <= 1'b0;
            phase_q    <= '0;
            dead_q     <= '0;
            pwm_cnt_q  <= '0;
            duty_eff_q <= '0;
            pwm_hi_q   <= '0;
            pwm_lo_q   <= '0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            step_cnt_q <= step_cnt_d;
            step_per_q <= step_per_d;
            stall_q    <= stall_d;
            phase_q    <= phase_d;
            dead_q     <= dead_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_eff_q <= duty_eff_d;
            pwm_hi_q   <= pwm_hi_d;
            pwm_lo_q   <= pwm_lo_d;
            running_q  <= running_d;
        end
    end

    assign phase_state = phase_q;
    assign pwm_hi      = pwm_hi_q;
    assign pwm_lo      = pwm_lo_q;
    assign running     = running_q;
endmodule
